// File: rtl/axis_pkt_rr_arbiter_32.sv
// -----------------------------------------------------------------------------
// axis_pkt_rr_arbiter_32
//
// Packet-level round-robin arbiter sharing one 32-bit AXI-Stream output (the
// slave port of the 32->128 upsizer) between NUM_SRC 32-bit requesters.
//
// - The grant is locked to one source from its first beat through its TLAST
//   beat, so packets are never interleaved on the output.
// - Arbitration takes one cycle in IDLE. The source that just finished has the
//   lowest priority at the next arbitration.
// - The output is a single registered stage that can load and drain in the
//   same cycle, which gives full rate inside a packet.
// - m_axis_tid carries the index of the source that produced each beat.
//
// Optional build macro:
//   AXIS_ARB_PKT_CNT_EN - adds the pkt_cnt output port, which holds one 16-bit
//                         wrapping count of completed packets per source.
//
// Reset is synchronous and active-low (aresetn), sampled on aclk.
// -----------------------------------------------------------------------------
module axis_pkt_rr_arbiter_32 #(
    parameter int NUM_SRC = 4,  // 1..16
    parameter int ID_W    = 2   // clog2(max(NUM_SRC,2))
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_SRC*32-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]    s_axis_tlast,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [ID_W-1:0]       m_axis_tid,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_idx
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*16-1:0] pkt_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Registered state and output stage
    state_t          state_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] last_grant_q;
    logic [31:0]     m_tdata_q;
    logic            m_tlast_q;
    logic [ID_W-1:0] m_tid_q;
    logic            m_tvalid_q;

    // Combinational view of the granted source
    logic            g_valid;
    logic            g_last;
    logic [31:0]     g_data;

    // Arbitration result for the next grant
    logic            any_valid;
    logic            hi_found;
    logic [ID_W-1:0] sel_hi;
    logic [ID_W-1:0] sel_lo;
    logic [ID_W-1:0] arb_sel_d;

    // Handshake helpers
    logic            out_free;
    logic            ld;

    // Select the data, last and valid of the currently granted source.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves a value unassigned (no latch).
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                g_data  = s_axis_tdata[i*32 +: 32];
            end
        end
    end

    // Round-robin pick: lowest requester above last_grant, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        // Scan downward so the last hit is the lowest index in each range.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                sel_lo = ID_W'(i);
                if (i > int'(last_grant_q)) begin
                    sel_hi   = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        arb_sel_d = hi_found ? sel_hi : sel_lo;
    end

    assign any_valid = |s_axis_tvalid;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_tvalid_q || m_axis_tready;

    // A beat moves from the granted source into the output register.
    assign ld = (state_q == ST_BUSY) && g_valid && out_free;

    // Only the granted source sees ready, and only while the output can load.
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state_q == ST_BUSY) && (grant_q == ID_W'(i))) begin
                s_axis_tready[i] = out_free;
            end
        end
    end

    // Grant FSM plus the registered output stage.
    always_ff @(posedge aclk) begin
        // NOTE: all state in clocked blocks uses non-blocking assignments so
        // every register samples the pre-edge values of every other register.
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
            m_tvalid_q   <= 1'b0;
        end else begin
            // A load in the same cycle as an accept keeps tvalid high.
            if (ld) begin
                m_tdata_q  <= g_data;
                m_tlast_q  <= g_last;
                m_tid_q    <= grant_q;
                m_tvalid_q <= 1'b1;
            end else if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_q <= arb_sel_d;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A stalled source keeps the grant: no timeout, no preemption.
                    if (ld && g_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tid    = m_tid_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign busy          = (state_q == ST_BUSY);
    assign grant_idx     = grant_q;

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt_q [NUM_SRC];

    // Count completed packets per source; 16-bit wrap is intentional.
    always_ff @(posedge aclk) begin
        // NOTE: this array is a handful of flops rather than a RAM, so it is
        // reset along with the rest of the state.
        if (!aresetn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (ld && g_last && (grant_q == ID_W'(i))) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pkt_cnt
        assign pkt_cnt[gi*16 +: 16] = pkt_cnt_q[gi];
    end
`endif

endmodule

// File: doc/axis_pkt_rr_arbiter_32.md
Name: axis_pkt_rr_arbiter_32

Overview:
- Packet-level round-robin arbiter that shares the 32→128 stream upsizer between NUM_SRC 32-bit AXI-Stream requesters.
- Grant is locked to one source from its first beat through its TLAST beat, so the upsizer never sees interleaved packets.
- Output is a registered 32-bit AXI-Stream that feeds the upsizer slave port directly.
- The source index travels alongside the data on m_axis_tid.

Parameters:
- NUM_SRC, 4, number of requesting 32-bit stream sources (1..16).
- ID_W, 2, width of the source index. Must equal clog2(max(NUM_SRC,2)).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  NUM_SRC*32  source data; source i occupies bits [32i+31:32i]
- s_axis_tlast  in  NUM_SRC  per-source end of packet
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready
- m_axis_tdata  out  32  data to upsizer
- m_axis_tlast  out  1  end of packet to upsizer
- m_axis_tid  out  ID_W  index of the source that produced the beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  upsizer ready
- busy  out  1  high while a packet is granted (state BUSY)
- grant_idx  out  ID_W  current or most recent granted source

Behaviour:
- Reset values: m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, m_axis_tvalid=0, busy=0, grant_idx=0, state=IDLE, last_grant=NUM_SRC-1 (so source 0 wins first).
- Reset mid-packet: the partial packet is abandoned, the output register is cleared, and no TLAST is synthesised.
- Output register:
  - Beat accepted when m_axis_tvalid && m_axis_tready → m_axis_tvalid<=0 unless a new beat loads in the same cycle.
  - A load in the same cycle wins: tvalid stays 1 with no bubble.
- Load condition: ld = s_axis_tvalid[g] && s_axis_tready[g], where g = grant_idx.
- State IDLE:
  - All s_axis_tready=0.
  - The output register may still drain.
  - If any s_axis_tvalid is set: pick the first set bit scanning (last_grant+1) mod NUM_SRC upward with wrap; grant_idx<=sel; state<=BUSY.
  - Arbitration costs exactly 1 cycle.
- State BUSY:
  - s_axis_tready[g] = !m_axis_tvalid || m_axis_tready. All other readies are 0.
  - On ld: m_axis_tdata<=slice g, m_axis_tlast<=s_axis_tlast[g], m_axis_tid<=g, m_axis_tvalid<=1.
  - On ld with s_axis_tlast[g]: last_grant<=g; state<=IDLE.
- Granted source drops tvalid mid-packet: the grant is held indefinitely. There is no timeout and no preemption.
- Non-granted sources asserting tvalid see tready=0 and must hold their data (AXIS rule).
- Single-beat packet (TLAST on first beat): sequence is IDLE→BUSY for 1 cycle→IDLE.
- Throughput:
  - Full rate within a packet.
  - One idle cycle of arbitration between packets.
  - Sustained rate for P-beat packets is P/(P+1).
- NUM_SRC=1: always grants 0; behaviour is otherwise identical.
- Fairness: a source that just finished has the lowest priority at the next arbitration.
- busy is high in state BUSY. grant_idx holds its value through IDLE until the next grant.

Optional Feature:
- Macro: AXIS_ARB_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_cnt, NUM_SRC*16 bits. Slice i counts completed packets from source i.
  - The count increments on ld with TLAST, wraps 0xFFFF→0, and is reset to 0.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: all outputs 0 and all s_axis_tready=0. After aresetn rises with source 2 valid, grant_idx=2 after 1 cycle, and the first beat appears on m_axis with tid=2.
- Sources 0..3 each present one 4-beat packet continuously, m_axis_tready=1: output order is src0,1,2,3, each 4 beats contiguous with TLAST on the 4th beat. Exactly one bubble between packets; 16 beats in 19 cycles after the first grant.
- Round-robin wrap: last_grant=3, sources 1 and 3 valid → source 1 granted. Next arbitration with both still valid → source 3 granted.
- Backpressure: src0 sends 5 words 0xA0..0xA4, with m_axis_tready toggling 1,0,0,1,… → no beat dropped or duplicated, tdata order A0..A4, TLAST only on A4, and s_axis_tready[0] low whenever m_axis_tvalid=1 && m_axis_tready=0.
- Mid-packet stall and reset: src1 sends 2 of 3 beats, then drops tvalid for 10 cycles while src0 is valid → src0 is never granted during the stall. Then aresetn=0 for 1 cycle → state IDLE, m_axis_tvalid=0, and the next grant goes to src0.
- With AXIS_ARB_PKT_CNT_EN: after 3 packets from src2 and 1 from src0, pkt_cnt slice 2=3 and slice 0=1. With a preload to 0xFFFF, one more packet gives 0.
